color_config_ctrl: RTL and testbench

COLOR_CONFIG_CTRL -- requirements
Module: color_config_ctrl

---
 rtl/color_pkg.sv | 26 ++
 rtl/color_reg_bank.sv | 30 +++
 rtl/color_config_ctrl.sv | 106 ++++++++++
 tb/tb_color_config_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared definitions for the colour configuration controller: register addresses,
// controller state encoding and power-on colour defaults (RGB332).
package color_pkg;

    localparam logic [2:0] ADDR_LINE       = 3'd0;
    localparam logic [2:0] ADDR_FLOOR      = 3'd1;
    localparam logic [2:0] ADDR_CEILING    = 3'd2;
    localparam logic [2:0] ADDR_BACKGROUND = 3'd3;

    localparam logic [7:0] DEF_LINE       = 8'hFF;
    localparam logic [7:0] DEF_FLOOR      = 8'h49;
    localparam logic [7:0] DEF_CEILING    = 8'h92;
    localparam logic [7:0] DEF_BACKGROUND = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    // Addresses above the background slot are reserved and map to no register.
    function automatic logic is_color_addr(input logic [2:0] addr);
        return addr <= ADDR_BACKGROUND;
    endfunction

endpackage

// File: rtl/color_reg_bank.sv
// Four 8-bit colour registers with an addressed write port and a parallel load
// that copies a whole set at once; the parallel load wins over a single write.
module color_reg_bank #(
    parameter logic [3:0][7:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [1:0]      wr_addr,
    input  logic [7:0]      wr_data,
    input  logic            load_en,
    input  logic [3:0][7:0] load_data,
    output logic [3:0][7:0] rd_data
);

    logic [3:0][7:0] regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= RST_VAL;
        end else if (load_en) begin
            regs <= load_data;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data = regs;

endmodule

// File: rtl/color_config_ctrl.sv
// Double-buffered colour configuration: the host writes a shadow set, and a commit
// copies it to the active set only at a frame boundary so the picture never tears.
module color_config_ctrl
    import color_pkg::*;
#(
    parameter logic [7:0] RST_LINE       = DEF_LINE,
    parameter logic [7:0] RST_FLOOR      = DEF_FLOOR,
    parameter logic [7:0] RST_CEILING    = DEF_CEILING,
    parameter logic [7:0] RST_BACKGROUND = DEF_BACKGROUND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit_req,
    input  logic       frame_start,
    output logic [7:0] line_color,
    output logic [7:0] floor_color,
    output logic [7:0] ceiling_color,
    output logic [7:0] background_color,
    output logic       commit_pending,
    output logic       commit_done
);

    // Register index 0 is the line colour, matching ADDR_LINE.
    localparam logic [3:0][7:0] RST_SET = {RST_BACKGROUND, RST_CEILING, RST_FLOOR, RST_LINE};

    state_t          state;
    state_t          state_nxt;
    logic            ready_st;
    logic            apply;
    logic            shadow_we;
    logic [3:0][7:0] shadow_q;
    logic [3:0][7:0] active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            commit_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            commit_done <= apply;
        end
    end

    always_comb begin
        state_nxt      = state;
        ready_st       = 1'b0;
        commit_pending = 1'b0;
        apply          = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_st = 1'b1;
                if (commit_req) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                commit_pending = 1'b1;
                if (frame_start) state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                commit_pending = 1'b1;
                apply          = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Held low while reset is asserted so the host cannot write into a clearing bank.
    assign wr_ready  = rst_n && ready_st;
    assign shadow_we = wr_valid && wr_ready && is_color_addr(wr_addr);

    color_reg_bank #(
        .RST_VAL (RST_SET)
    ) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (shadow_we),
        .wr_addr   (wr_addr[1:0]),
        .wr_data   (wr_data),
        .load_en   (1'b0),
        .load_data ('0),
        .rd_data   (shadow_q)
    );

    color_reg_bank #(
        .RST_VAL (RST_SET)
    ) u_active (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (1'b0),
        .wr_addr   (2'b00),
        .wr_data   (8'h00),
        .load_en   (apply),
        .load_data (shadow_q),
        .rd_data   (active_q)
    );

    assign line_color       = active_q[0];
    assign floor_color      = active_q[1];
    assign ceiling_color    = active_q[2];
    assign background_color = active_q[3];

endmodule

// File: tb/tb_color_config_ctrl.sv
// Bench for color_config_ctrl: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the shadow/active colour sets.
module tb_color_config_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       commit_req = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] line_color, floor_color, ceiling_color, background_color;
    logic       commit_pending, commit_done;

    int n_checks = 0;
    int n_errors = 0;

    color_config_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .commit_req       (commit_req),
        .frame_start      (frame_start),
        .line_color       (line_color),
        .floor_color      (floor_color),
        .ceiling_color    (ceiling_color),
        .background_color (background_color),
        .commit_pending   (commit_pending),
        .commit_done      (commit_done)
    );

    always #5 clk = ~clk;

    // Reference model: colour sets as arrays; a commit is "waiting for a frame",
    // then "copying"; the host may only write while no commit is outstanding.
    logic [7:0] rst_colors [4];
    logic [7:0] m_shadow   [4];
    logic [7:0] m_active   [4];
    bit         m_wait_frame;
    bit         m_copying;
    bit         m_done;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] b2v(input logic b);
        return {7'b0, b};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = rst_colors[i];
            m_active[i] = rst_colors[i];
        end
        m_wait_frame = 1'b0;
        m_copying    = 1'b0;
        m_done       = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        bit busy;
        busy = m_wait_frame || m_copying;
        check({tag, ".line"},    line_color,       m_active[0]);
        check({tag, ".floor"},   floor_color,      m_active[1]);
        check({tag, ".ceiling"}, ceiling_color,    m_active[2]);
        check({tag, ".bg"},      background_color, m_active[3]);
        check({tag, ".pending"}, b2v(commit_pending), b2v(busy));
        check({tag, ".done"},    b2v(commit_done),    b2v(m_done));
        check({tag, ".ready"},   b2v(wr_ready),       b2v(!busy));
    endtask

    // Advance one clock: predict from the inputs present now, then compare after the edge.
    task automatic cycle(input string tag);
        bit busy;
        busy   = m_wait_frame || m_copying;
        m_done = 1'b0;
        if (m_copying) begin
            for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
            m_copying = 1'b0;
            m_done    = 1'b1;
        end else if (m_wait_frame) begin
            if (frame_start) begin
                m_wait_frame = 1'b0;
                m_copying    = 1'b1;
            end
        end else begin
            if (wr_valid && wr_addr < 3'd4) m_shadow[wr_addr[1:0]] = wr_data;
            if (commit_req) m_wait_frame = 1'b1;
        end
        @(posedge clk);
        #1;
        commit_req  = 1'b0;
        frame_start = 1'b0;
        check_outputs(tag);
        if (!busy) wr_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        cycle("write");
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".line"},    line_color,       rst_colors[0]);
        check({tag, ".floor"},   floor_color,      rst_colors[1]);
        check({tag, ".ceiling"}, ceiling_color,    rst_colors[2]);
        check({tag, ".bg"},      background_color, rst_colors[3]);
        check({tag, ".pending"}, b2v(commit_pending), 8'h00);
        check({tag, ".done"},    b2v(commit_done),    8'h00);
        check({tag, ".ready_in_rst"}, b2v(wr_ready),  8'h00);
        wr_valid    = 1'b0;
        commit_req  = 1'b0;
        frame_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_outputs({tag, ".after"});
    endtask

    initial begin
        rst_colors[0] = 8'hFF;
        rst_colors[1] = 8'h49;
        rst_colors[2] = 8'h92;
        rst_colors[3] = 8'h00;
        model_reset();

        // Power-on reset and idle outputs
        #12;
        do_reset("por");
        idle_cycles(3, "idle");

        // Writes without commit never reach the outputs, whatever frames go by
        host_write(3'd0, 8'hE0);
        host_write(3'd2, 8'h03);
        for (int i = 0; i < 3; i++) begin
            frame_start = 1'b1;
            cycle("nocommit_frame");
            idle_cycles(4, "nocommit");
        end
        check("nocommit.line_fixed", line_color, 8'hFF);

        // Commit latency: frame_start at N -> colours and commit_done at N+2
        host_write(3'd1, 8'h1C);
        commit_req = 1'b1;
        cycle("commit_arm");
        idle_cycles(5, "armed_wait");
        frame_start = 1'b1;
        cycle("apply_cycle");
        check("lat.floor_not_yet", floor_color, 8'h49);
        cycle("apply_edge");
        check("lat.floor_new", floor_color, 8'h1C);
        check("lat.done", b2v(commit_done), 8'h01);
        cycle("after_apply");
        check("lat.done_once", b2v(commit_done), 8'h00);

        // Write in the same cycle as commit_req joins that commit
        wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A; commit_req = 1'b1;
        cycle("write_commit");
        frame_start = 1'b1;
        cycle("wc_frame");
        cycle("wc_apply");
        check("wc.bg", background_color, 8'h5A);

        // commit_req together with frame_start only arms; apply waits for the next frame
        host_write(3'd0, 8'h11);
        commit_req = 1'b1; frame_start = 1'b1;
        cycle("same_cycle");
        idle_cycles(100, "wait_second_frame");
        check("same.line_unchanged", line_color, 8'hE0);
        frame_start = 1'b1;
        cycle("second_frame");
        cycle("second_apply");
        check("same.line_new", line_color, 8'h11);

        // Held write stalls through ARMED/APPLY, lands afterwards in shadow only
        commit_req = 1'b1;
        cycle("stall_arm");
        wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'hFF;
        commit_req = 1'b1;
        idle_cycles(4, "stall_armed");
        frame_start = 1'b1;
        cycle("stall_frame");
        cycle("stall_apply");
        check("stall.ready_back", b2v(wr_ready), 8'h01);
        cycle("stall_accept");
        check("stall.bg_still", background_color, 8'h5A);
        commit_req = 1'b1;
        cycle("stall_commit");
        frame_start = 1'b1;
        cycle("stall_frame2");
        cycle("stall_apply2");
        check("stall.bg_ff", background_color, 8'hFF);

        // Reserved addresses are consumed without touching any colour
        host_write(3'd5, 8'hAA);
        host_write(3'd7, 8'h55);
        commit_req = 1'b1;
        cycle("rsv_commit");
        frame_start = 1'b1;
        cycle("rsv_frame");
        cycle("rsv_apply");

        // Reset while ARMED abandons the commit
        do_reset("clean");
        host_write(3'd0, 8'hE0);
        commit_req = 1'b1;
        cycle("rst_arm");
        idle_cycles(2, "rst_armed");
        do_reset("rst_armed");
        check("rst_armed.line", line_color, 8'hFF);
        frame_start = 1'b1;
        cycle("rst_frame");
        idle_cycles(3, "rst_no_done");

        // Random traffic, including occasional resets during any phase
        for (int i = 0; i < 1500; i++) begin
            wr_valid    = ($urandom_range(0, 1) == 1);
            wr_addr     = 3'($urandom_range(0, 7));
            wr_data     = 8'($urandom);
            commit_req  = ($urandom_range(0, 7) == 0);
            frame_start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
            else cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
